// File: rtl/dcu_frame_assembler.sv
`default_nettype none
// ============================================================================
//  Module   : dcu_frame_assembler
//  Brief    : Buffers one frame (SIGNAL symbol plus up to MAX_SYM payload
//             symbols of K active samples each) and replays it as N-sample
//             symbols with zero guard bins and a CP_LEN idle gap between
//             symbols. The output is valid/ready with prefetch, so there are
//             no bubbles while do_rdy is high.
//  Revision : 1.0 - initial release
// ============================================================================
module dcu_frame_assembler #(
    parameter int DW       = 12,
    parameter int N        = 512,
    parameter int GUARD_LO = 27,
    parameter int GUARD_HI = 26,
    parameter int CP_LEN   = 32,
    parameter int MAX_SYM  = 15,
    parameter int SYM_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             new_frame,
    input  logic [SYM_W-1:0] pld_num,
    input  logic [DW-1:0]    sig_di_re,
    input  logic [DW-1:0]    sig_di_im,
    input  logic             sig_di_vld,
    input  logic [DW-1:0]    pld_di_re,
    input  logic [DW-1:0]    pld_di_im,
    input  logic             pld_di_vld,
    output logic [DW-1:0]    do_re,
    output logic [DW-1:0]    do_im,
    output logic             do_vld,
    input  logic             do_rdy,
    output logic             do_sym_last,
    output logic             do_frame_last,
    output logic             busy,
    output logic             err_ovf
);

    // Active samples per symbol and derived widths.
    localparam int c_K   = N - GUARD_LO - GUARD_HI;
    localparam int c_KW  = $clog2(c_K + 1);
    localparam int c_SAW = (c_K > 1) ? $clog2(c_K) : 1;
    localparam int c_PD  = MAX_SYM * c_K;
    localparam int c_PAW = (c_PD > 1) ? $clog2(c_PD) : 1;
    localparam int c_PCW = $clog2(c_PD + 1);
    localparam int c_NW  = $clog2(N);
    localparam int c_CPW = (CP_LEN > 1) ? $clog2(CP_LEN) : 1;

    localparam logic [c_NW-1:0]  c_GLO       = c_NW'(GUARD_LO);
    localparam logic [c_NW-1:0]  c_GHI_START = c_NW'(N - GUARD_HI);
    localparam logic [c_NW-1:0]  c_KLAST     = c_NW'(N - 1);
    localparam logic [c_KW-1:0]  c_KFULL     = c_KW'(c_K);
    localparam logic [c_CPW-1:0] c_GAP_END   = c_CPW'(CP_LEN - 1);
    localparam logic [SYM_W-1:0] c_MAXS      = SYM_W'(MAX_SYM);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_OUT  = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [SYM_W-1:0]   num_q, num_d;
    logic [SYM_W-1:0]   s_q, s_d;
    logic [c_KW-1:0]    sig_wcnt_q, sig_wcnt_d;
    logic [c_PCW-1:0]   pld_wcnt_q, pld_wcnt_d;
    logic [c_NW-1:0]    k_q, k_d;
    logic [c_SAW-1:0]   act_q, act_d;
    logic [c_PAW-1:0]   prd_q, prd_d;
    logic [c_CPW-1:0]   gap_q, gap_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;
    logic               vld_q, vld_d;
    logic               sym_last_q, sym_last_d;
    logic               frame_last_q, frame_last_d;
    logic               zero_q, zero_d;
    logic               src_sig_q, src_sig_d;

    logic               sig_we, pld_we, sig_re, pld_re;
    logic [2*DW-1:0]    sig_mem [c_K];
    logic [2*DW-1:0]    pld_mem [c_PD];
    logic [2*DW-1:0]    sig_rd_q, pld_rd_q;

    logic [c_PCW-1:0]   w_pld_target;
    logic               w_num_ovf;
    logic               w_sig_room, w_pld_room, w_full;
    logic               w_guard, w_issue, w_xfer, w_out_on;
    logic [2*DW-1:0]    w_sel;

    assign w_pld_target = c_PCW'(num_q) * c_PCW'(c_K);
    assign w_num_ovf    = (pld_num > c_MAXS);
    assign w_sig_room   = (sig_wcnt_q < c_KFULL);
    assign w_pld_room   = (pld_wcnt_q < w_pld_target);
    assign w_full       = (sig_wcnt_q == c_KFULL) && (pld_wcnt_q == w_pld_target);
    assign w_guard      = (k_q < c_GLO) || (k_q >= c_GHI_START);
    assign w_xfer       = vld_q && do_rdy;

    // Load the next sample into the output stage: at the end of FILL, at the
    // last GAP cycle, or in OUT whenever the output slot is free or draining
    // and the symbol's final sample has not yet been loaded.
    assign w_issue = ((state_q == S_FILL) && w_full)
                  || ((state_q == S_GAP) && (gap_q == c_GAP_END))
                  || ((state_q == S_OUT) && !(vld_q && sym_last_q) && (!vld_q || do_rdy));

    // Next-state logic for the frame FSM, write counters and output stage.
    always_comb begin
        state_d      = state_q;
        num_d        = num_q;
        s_d          = s_q;
        sig_wcnt_d   = sig_wcnt_q;
        pld_wcnt_d   = pld_wcnt_q;
        k_d          = k_q;
        act_d        = act_q;
        prd_d        = prd_q;
        gap_d        = gap_q;
        busy_d       = busy_q;
        err_d        = err_q;
        vld_d        = vld_q;
        sym_last_d   = sym_last_q;
        frame_last_d = frame_last_q;
        zero_d       = zero_q;
        src_sig_d    = src_sig_q;
        sig_we       = 1'b0;
        pld_we       = 1'b0;
        sig_re       = 1'b0;
        pld_re       = 1'b0;

        if (new_frame) begin
            state_d      = S_IDLE;
            num_d        = w_num_ovf ? c_MAXS : pld_num;
            err_d        = w_num_ovf;
            s_d          = '0;
            sig_wcnt_d   = '0;
            pld_wcnt_d   = '0;
            k_d          = '0;
            act_d        = '0;
            prd_d        = '0;
            gap_d        = '0;
            busy_d       = 1'b0;
            vld_d        = 1'b0;
            sym_last_d   = 1'b0;
            frame_last_d = 1'b0;
            zero_d       = 1'b0;
            src_sig_d    = 1'b0;
        end else begin
            // Input acceptance; anything beyond the expected counts is dropped.
            if ((state_q == S_IDLE) || (state_q == S_FILL)) begin
                if (sig_di_vld) begin
                    if (w_sig_room) begin
                        sig_we     = 1'b1;
                        sig_wcnt_d = sig_wcnt_q + 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (pld_di_vld) begin
                    if (w_pld_room) begin
                        pld_we     = 1'b1;
                        pld_wcnt_d = pld_wcnt_q + 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if ((state_q == S_IDLE) && (sig_di_vld || pld_di_vld)) begin
                    state_d = S_FILL;
                    busy_d  = 1'b1;
                end
            end else if (sig_di_vld || pld_di_vld) begin
                err_d = 1'b1;
            end

            if (w_issue) begin
                state_d      = S_OUT;
                vld_d        = 1'b1;
                zero_d       = w_guard;
                src_sig_d    = (s_q == '0);
                sym_last_d   = (k_q == c_KLAST);
                frame_last_d = (k_q == c_KLAST) && (s_q == num_q);
                if (!w_guard) begin
                    act_d = act_q + 1'b1;
                    if (s_q == '0) begin
                        sig_re = 1'b1;
                    end else begin
                        pld_re = 1'b1;
                        prd_d  = prd_q + 1'b1;
                    end
                end
                if (k_q == c_KLAST) begin
                    k_d   = '0;
                    act_d = '0;
                    s_d   = s_q + 1'b1;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end else if ((state_q == S_OUT) && w_xfer) begin
                // Only the symbol's final sample can drain without a refill.
                vld_d        = 1'b0;
                sym_last_d   = 1'b0;
                frame_last_d = 1'b0;
                if (frame_last_q) begin
                    state_d    = S_IDLE;
                    busy_d     = 1'b0;
                    s_d        = '0;
                    sig_wcnt_d = '0;
                    pld_wcnt_d = '0;
                    k_d        = '0;
                    act_d      = '0;
                    prd_d      = '0;
                end else begin
                    state_d = S_GAP;
                    gap_d   = '0;
                end
            end else if (state_q == S_GAP) begin
                gap_d = gap_q + 1'b1;
            end
        end
    end

    // State and control registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            num_q        <= '0;
            s_q          <= '0;
            sig_wcnt_q   <= '0;
            pld_wcnt_q   <= '0;
            k_q          <= '0;
            act_q        <= '0;
            prd_q        <= '0;
            gap_q        <= '0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            vld_q        <= 1'b0;
            sym_last_q   <= 1'b0;
            frame_last_q <= 1'b0;
            zero_q       <= 1'b0;
            src_sig_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            num_q        <= num_d;
            s_q          <= s_d;
            sig_wcnt_q   <= sig_wcnt_d;
            pld_wcnt_q   <= pld_wcnt_d;
            k_q          <= k_d;
            act_q        <= act_d;
            prd_q        <= prd_d;
            gap_q        <= gap_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
            vld_q        <= vld_d;
            sym_last_q   <= sym_last_d;
            frame_last_q <= frame_last_d;
            zero_q       <= zero_d;
            src_sig_q    <= src_sig_d;
        end
    end

    // Sample RAMs with registered, enabled reads; the read register doubles as
    // the output data stage so it holds while the output is stalled.
    always_ff @(posedge clk) begin
        if (sig_we) sig_mem[sig_wcnt_q[c_SAW-1:0]] <= {sig_di_re, sig_di_im};
        if (pld_we) pld_mem[pld_wcnt_q[c_PAW-1:0]] <= {pld_di_re, pld_di_im};
        if (sig_re) sig_rd_q <= sig_mem[act_q];
        if (pld_re) pld_rd_q <= pld_mem[prd_q];
    end

    // Guard bins and idle cycles force zero data; the RAM registers have no
    // reset, so gating on vld_q keeps the outputs at zero after any reset.
    assign w_out_on      = vld_q && !zero_q;
    assign w_sel         = src_sig_q ? sig_rd_q : pld_rd_q;
    assign do_re         = w_out_on ? w_sel[2*DW-1:DW] : '0;
    assign do_im         = w_out_on ? w_sel[DW-1:0]    : '0;
    assign do_vld        = vld_q;
    assign do_sym_last   = sym_last_q;
    assign do_frame_last = frame_last_q;
    assign busy          = busy_q;
    assign err_ovf       = err_q;

endmodule
`default_nettype wire
